// File: rtl/gift_cofb_ks_seq.sv
// GIFT-COFB key-schedule sequencer: loads a 128-bit key in four beats, then
// emits ROUNDS (U,V) round-key pairs, using an external ISE unit for each update.
module gift_cofb_ks_seq #(
  parameter int unsigned ROUNDS = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  output logic        key_ready,
  input  logic [31:0] key_word,
  input  logic        abort,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [31:0] rk_u,
  output logic [31:0] rk_v,
  output logic [5:0]  rk_idx,
  output logic        rk_last,
  output logic        busy,
  output logic        ise_op_keyupdate,
  output logic [31:0] ise_rs1,
  output logic [4:0]  ise_imm,
  input  logic [31:0] ise_rd
);

  localparam int unsigned WW = 32;
  localparam int unsigned RW = 6;
  localparam logic [RW-1:0] LAST_R = RW'(ROUNDS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, EMIT, UPDATE} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   w_q [4];
  logic [WW-1:0]   w_d [4];
  logic [RW-1:0]   round_q, round_d;
  logic [1:0]      beat_q, beat_d;

  logic            key_ready_d, rk_valid_d, rk_last_d, busy_d, ise_op_d;
  logic [WW-1:0]   rk_u_d, rk_v_d, ise_rs1_d;
  logic [RW-1:0]   rk_idx_d;

  assign ise_imm = 5'd0;

  // State, key words and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      for (int i = 0; i < 4; i++) w_q[i] <= '0;
      round_q          <= '0;
      beat_q           <= '0;
      key_ready        <= 1'b1;
      rk_valid         <= 1'b0;
      rk_u             <= '0;
      rk_v             <= '0;
      rk_idx           <= '0;
      rk_last          <= 1'b0;
      busy             <= 1'b0;
      ise_op_keyupdate <= 1'b0;
      ise_rs1          <= '0;
    end else begin
      state_q          <= state_d;
      for (int i = 0; i < 4; i++) w_q[i] <= w_d[i];
      round_q          <= round_d;
      beat_q           <= beat_d;
      key_ready        <= key_ready_d;
      rk_valid         <= rk_valid_d;
      rk_u             <= rk_u_d;
      rk_v             <= rk_v_d;
      rk_idx           <= rk_idx_d;
      rk_last          <= rk_last_d;
      busy             <= busy_d;
      ise_op_keyupdate <= ise_op_d;
      ise_rs1          <= ise_rs1_d;
    end
  end

  // Next state; abort overrides every transition and clears the key
  always_comb begin
    state_d = state_q;
    for (int i = 0; i < 4; i++) w_d[i] = w_q[i];
    round_d = round_q;
    beat_d  = beat_q;
    if (abort) begin
      state_d = IDLE;
      for (int i = 0; i < 4; i++) w_d[i] = '0;
      round_d = '0;
      beat_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_valid) begin
            w_d[0]  = key_word;
            beat_d  = 2'd1;
            state_d = LOAD;
          end
        end
        LOAD: begin
          if (key_valid) begin
            w_d[beat_q] = key_word;
            beat_d      = beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              state_d = EMIT;
              round_d = '0;
            end
          end
        end
        EMIT: begin
          if (rk_ready) state_d = (round_q == LAST_R) ? IDLE : UPDATE;
        end
        UPDATE: begin
          w_d[0]  = w_q[1];
          w_d[1]  = w_q[2];
          w_d[2]  = w_q[3];
          w_d[3]  = ise_rd;
          round_d = round_q + RW'(1);
          state_d = EMIT;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output values decoded from the next state so the ports come straight from flops
  always_comb begin
    key_ready_d = (state_d == IDLE) || (state_d == LOAD);
    rk_valid_d  = (state_d == EMIT);
    busy_d      = (state_d != IDLE);
    ise_op_d    = (state_d == UPDATE);
    rk_u_d      = rk_valid_d ? w_d[2] : '0;
    rk_v_d      = rk_valid_d ? w_d[0] : '0;
    rk_idx_d    = rk_valid_d ? round_d : '0;
    rk_last_d   = rk_valid_d && (round_d == LAST_R);
    ise_rs1_d   = ise_op_d ? w_d[0] : '0;
  end

endmodule

// File: tb/tb_gift_cofb_ks_seq.sv
// Directed bench for gift_cofb_ks_seq with a behavioural ISE key-update unit.
module tb_gift_cofb_ks_seq;

  localparam int unsigned ROUNDS = 40;

  logic        clk, rst_n;
  logic        key_valid, key_ready;
  logic [31:0] key_word;
  logic        abort;
  logic        rk_valid, rk_ready;
  logic [31:0] rk_u, rk_v;
  logic [5:0]  rk_idx;
  logic        rk_last, busy, ise_op_keyupdate;
  logic [31:0] ise_rs1, ise_rd;
  logic [4:0]  ise_imm;

  int n_pass = 0;
  int n_total = 0;

  gift_cofb_ks_seq #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_valid(key_valid), .key_ready(key_ready), .key_word(key_word),
    .abort(abort),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_u(rk_u), .rk_v(rk_v),
    .rk_idx(rk_idx), .rk_last(rk_last), .busy(busy),
    .ise_op_keyupdate(ise_op_keyupdate), .ise_rs1(ise_rs1),
    .ise_imm(ise_imm), .ise_rd(ise_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GIFT key-word update: k1 rotr 2 in the upper half, k0 rotr 12 in the lower half
  function automatic logic [31:0] ks_f(input logic [31:0] x);
    logic [15:0] a, b;
    a = x[31:16];
    b = x[15:0];
    return {a[1:0], a[15:2], b[11:0], b[15:12]};
  endfunction

  assign ise_rd = ks_f(ise_rs1);

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    for (int b = 0; b < 4; b++) begin
      key_valid = 1'b1;
      key_word  = k[32*b +: 32];
      chk("key_ready_load", 32'(key_ready), 32'd1);
      chk("rk_valid_during_load", 32'(rk_valid), 32'd0);
      tick();
    end
    key_valid = 1'b0;
    key_word  = '0;
    chk("first_rk_valid", 32'(rk_valid), 32'd1);
  endtask

  // Walks all rounds with a reference key model; optional stall, abort and hand-checked round
  task automatic run_key(input logic [127:0] k, input int stall_r, input int abort_r,
                         input int tbl_r, input logic [31:0] tu, input logic [31:0] tv);
    logic [31:0] m [4];
    logic [31:0] nm;
    for (int i = 0; i < 4; i++) m[i] = k[32*i +: 32];
    for (int r = 0; r < int'(ROUNDS); r++) begin
      chk("rk_valid", 32'(rk_valid), 32'd1);
      chk("rk_idx", 32'(rk_idx), 32'(r));
      chk("rk_u", rk_u, m[2]);
      chk("rk_v", rk_v, m[0]);
      chk("rk_last", 32'(rk_last), 32'(r == int'(ROUNDS) - 1));
      chk("key_ready_emit", 32'(key_ready), 32'd0);
      if (r == tbl_r) begin
        chk("tbl_u", rk_u, tu);
        chk("tbl_v", rk_v, tv);
      end
      if (r == stall_r) begin
        rk_ready  = 1'b0;
        key_valid = 1'b1;
        key_word  = 32'hdeadbeef;
        repeat (5) begin
          tick();
          chk("stall_valid", 32'(rk_valid), 32'd1);
          chk("stall_u", rk_u, m[2]);
          chk("stall_v", rk_v, m[0]);
          chk("stall_idx", 32'(rk_idx), 32'(r));
          chk("stall_no_update", 32'(ise_op_keyupdate), 32'd0);
          chk("stall_key_ready", 32'(key_ready), 32'd0);
        end
        rk_ready  = 1'b1;
        key_valid = 1'b0;
        key_word  = '0;
      end
      tick();
      if (r == int'(ROUNDS) - 1) begin
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_key_ready", 32'(key_ready), 32'd1);
        chk("done_rk_valid", 32'(rk_valid), 32'd0);
      end else begin
        chk("upd_strobe", 32'(ise_op_keyupdate), 32'd1);
        chk("upd_rs1", ise_rs1, m[0]);
        chk("upd_rk_valid", 32'(rk_valid), 32'd0);
        if (r == abort_r) begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          chk("abort_busy", 32'(busy), 32'd0);
          chk("abort_key_ready", 32'(key_ready), 32'd1);
          chk("abort_strobe", 32'(ise_op_keyupdate), 32'd0);
          repeat (3) begin
            chk("abort_rk_valid", 32'(rk_valid), 32'd0);
            tick();
          end
          return;
        end
        nm   = ks_f(m[0]);
        m[0] = m[1];
        m[1] = m[2];
        m[2] = m[3];
        m[3] = nm;
        tick();
      end
    end
  endtask

  typedef struct {
    logic [127:0] key;
    int           stall_r;
    int           abort_r;
    int           tbl_r;
    logic [31:0]  tu;
    logic [31:0]  tv;
  } vec_t;

  vec_t tbl [5];

  initial begin
    tbl[0] = '{128'h00000004_00000003_00000002_00000001, 2, -1, 0, 32'h00000003, 32'h00000001};
    tbl[1] = '{128'h00000004_00000003_00000002_00000001, -1, -1, 4, 32'h00000030, 32'h00000010};
    tbl[2] = '{128'h87654321_0fedcba9_9abcdef0_12345678, -1, 7, 2, 32'h048d6785, 32'h0fedcba9};
    tbl[3] = '{128'h00000000_00000000_00000000_00010000, -1, -1, 4, 32'h00000000, 32'h40000000};
    tbl[4] = '{128'h87654321_0fedcba9_9abcdef0_12345678, -1, -1, 4, 32'h43fbba9c, 32'h048d6785};

    rst_n = 1'b0; key_valid = 1'b0; key_word = '0; abort = 1'b0; rk_ready = 1'b1;
    #12;
    chk("rst_key_ready", 32'(key_ready), 32'd1);
    chk("rst_rk_valid", 32'(rk_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rk_u", rk_u, 32'd0);
    chk("rst_ise_rs1", ise_rs1, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_key_ready", 32'(key_ready), 32'd1);
    chk("post_rst_rk_valid", 32'(rk_valid), 32'd0);
    chk("post_rst_rk_last", 32'(rk_last), 32'd0);
    chk("post_rst_rk_idx", 32'(rk_idx), 32'd0);
    chk("post_rst_ise_op", 32'(ise_op_keyupdate), 32'd0);
    chk("ise_imm", 32'(ise_imm), 32'd0);

    for (int i = 0; i < 5; i++) begin
      load_key(tbl[i].key);
      run_key(tbl[i].key, tbl[i].stall_r, tbl[i].abort_r, tbl[i].tbl_r, tbl[i].tu, tbl[i].tv);
    end

    // Reset after two beats discards the partial key
    key_valid = 1'b1; key_word = 32'h11111111; tick();
    key_word = 32'h22222222; tick();
    rst_n = 1'b0; key_valid = 1'b0;
    #2;
    chk("midload_rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    for (int b = 0; b < 3; b++) begin
      key_valid = 1'b1; key_word = 32'(b + 1);
      tick();
      chk("fresh_load_no_valid", 32'(rk_valid), 32'd0);
      chk("fresh_load_busy", 32'(busy), 32'd1);
    end
    key_word = 32'd4; tick();
    key_valid = 1'b0; key_word = '0;
    chk("fresh_load_valid", 32'(rk_valid), 32'd1);
    chk("fresh_load_u", rk_u, 32'd3);

    // Reset while emitting keeps rk_valid low afterwards
    rst_n = 1'b0;
    #2;
    chk("midemit_rst_valid", 32'(rk_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("midemit_post_valid", 32'(rk_valid), 32'd0);
    end
    load_key(tbl[0].key);
    run_key(tbl[0].key, -1, -1, 0, 32'h00000003, 32'h00000001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
